fft_frame_serializer: RTL and testbench
=======================================

Name: fft_frame_serializer

Overview:
- Sits on the output side of the streaming radix-2 FFT (fft_N_rad2). It is the consumer of the FFT's parallel frame interface.
- Captures each N-bin frame presented with a one-cycle frame valid into a ping-pong register buffer.
- Streams the bins out one per cycle over a valid/ready handshake, optionally in fftshift order, toward the per-subcarrier OFDM post-processing.
- The FFT cannot be stalled, so frames arriving with no free buffer are dropped and counted.

Parameters:
- N, 8, FFT size; power of two, 8..256.
- FFTSHIFT, 0, 1 = emit bins in order N/2..N-1 then 0..N/2-1; 0 = natural order 0..N-1.
- IDX_W, $clog2(N), width of the bin index.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- frame_in  input  complex_product_t [N-1:0]  parallel FFT frame; bin k on element k.
- frame_valid  input  1  single-cycle strobe; frame_in is valid this cycle.
- frame_accept  output  1  a free buffer exists; a frame presented this cycle will be captured.
- sample_out  output  complex_product_t  current bin value; all zeros when sample_valid=0.
- sample_valid  output  1  sample_out holds a valid bin.
- sample_ready  input  1  downstream accepts sample_out this cycle.
- sample_bin  output  IDX_W  FFT bin number of sample_out.
- sample_first  output  1  first sample of a frame (emit position 0).
- sample_last  output  1  last sample of a frame (emit position N-1).
- drop_pulse  output  1  one-cycle pulse: the frame presented this cycle was discarded.
- drop_count  output  8  saturating count of dropped frames; holds at 255.

Behaviour:
- Storage
  - Two banks buf[0..1][0..N-1] of complex_product_t.
  - Flags full[1:0]; write pointer wr_sel; read pointer rd_sel; emit position pos [IDX_W-1:0].
- Capture
  - frame_accept = ~full[wr_sel], combinational from registers only.
  - If frame_valid and frame_accept at edge t: buf[wr_sel] <= frame_in, full[wr_sel] <= 1, wr_sel toggles.
- Drop
  - If frame_valid and ~frame_accept: no storage change.
  - drop_pulse = 1 in that cycle (combinational). drop_count increments at the edge, saturating at 255.
- Emit
  - sample_valid = full[rd_sel].
  - sample_bin = FFTSHIFT ? (pos ^ N/2) : pos.
  - sample_out = buf[rd_sel][sample_bin].
  - sample_first = sample_valid & (pos == 0); sample_last = sample_valid & (pos == N-1).
- Transfer
  - A transfer occurs when sample_valid & sample_ready; pos increments.
  - On a transfer with pos == N-1: pos wraps to 0, full[rd_sel] <= 0, rd_sel toggles.
  - Without sample_ready, all outputs hold stable (AXI-style; valid never drops without a transfer).
- Latency
  - A frame captured at edge t into an empty block gives sample_valid = 1 in cycle t+1.
  - With sample_ready held high, the N samples occupy cycles t+1..t+N.
  - Back-to-back frames stream gap-free whenever the second bank is already full when the first finishes.
- Simultaneous events
  - Capture and final transfer in the same cycle on different banks: both happen.
  - Final transfer frees a bank at the same edge a frame arrives while both banks are full: frame_accept uses the pre-edge flags, so the frame is dropped. The freed bank is writable from the next cycle.
  - frame_valid while empty and sample_ready=1: capture only; emission starts in the next cycle.
- Ordering: frames are emitted strictly in capture order; a bank is never overwritten while full.
- Reset (synchronous, takes priority over all activity, including mid-frame)
  - full=0, wr_sel=0, rd_sel=0, pos=0, drop_count=0.
  - Outputs: frame_accept=1, sample_valid=0, sample_out=0, sample_bin=0, sample_first=0, sample_last=0, drop_pulse=0.
  - Bank contents are not cleared and are not observable until rewritten.
- Width: no arithmetic on data; values pass bit-exact.

Test Plan:
- Single frame, N=8, FFTSHIFT=0, frame_in[k]=(re=k, im=-k), sample_ready=1.
  - Required: valid cycles t+1..t+8; sample_bin 0..7; sample_out=(k,-k); first at bin 0, last at bin 7; frame_accept=1 afterward.
- Same frame with FFTSHIFT=1.
  - Required: sample_bin sequence 4,5,6,7,0,1,2,3 with matching data; first on bin 4, last on bin 3.
- Backpressure: sample_ready toggles 1,0,0,1 repeating.
  - Required: outputs hold while ready=0; exactly 8 transfers; no duplicated or skipped bins.
- Overflow: sample_ready=0; frames A, B, C presented 3 cycles apart.
  - Required: A and B accepted; C gives drop_pulse=1 and frame_accept=0; drop_count=1.
  - Then ready=1: 16 samples, A then B, back-to-back with no gap.
- Coincidence: both banks full; frame D presented in the same cycle as A's last transfer.
  - Required: D dropped (drop_count +1); a frame E one cycle later is accepted and emitted after B.
- Reset mid-frame after 3 transfers.
  - Required: next cycle sample_valid=0, drop_count=0, frame_accept=1.
  - A new frame then emits starting at emit position 0 (bin 0, or bin N/2 with FFTSHIFT=1).

Source files
------------

// File: rtl/fft_frame_serializer.sv
// fft_frame_serializer
//   Consumer of the streaming FFT's parallel frame interface. Each N-bin
//   frame strobed by frame_valid is captured into one of two register banks
//   (ping-pong). The captured frames are then streamed out one bin per cycle
//   over a valid/ready handshake, in natural or fftshift order. The FFT
//   cannot be stalled, so a frame arriving while no bank is free is dropped
//   and counted.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   frame_in       parallel frame, bin k on element k
//   frame_valid    one-cycle strobe qualifying frame_in
//   frame_accept   a free bank exists; a frame presented now is captured
//   sample_out     current bin value (zero when sample_valid is low)
//   sample_valid   sample_out holds a valid bin
//   sample_ready   downstream accepts sample_out this cycle
//   sample_bin     FFT bin number of sample_out (zero when not valid)
//   sample_first   emit position 0 of a frame
//   sample_last    emit position N-1 of a frame
//   drop_pulse     the frame presented this cycle is discarded
//   drop_count     saturating count of dropped frames (holds at 255)

package fft_frame_serializer_pkg;
  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } complex_product_t;
endpackage

module fft_frame_serializer
  import fft_frame_serializer_pkg::*;
#(
  parameter int N        = 8,
  parameter int FFTSHIFT = 0,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  complex_product_t [N-1:0] frame_in,
  input  logic                     frame_valid,
  output logic                     frame_accept,
  output complex_product_t         sample_out,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic [IDX_W-1:0]         sample_bin,
  output logic                     sample_first,
  output logic                     sample_last,
  output logic                     drop_pulse,
  output logic [7:0]               drop_count
);

  complex_product_t [N-1:0] bank [2];
  logic [1:0]       full;
  logic             wr_sel;
  logic             rd_sel;
  logic [IDX_W-1:0] pos;
  logic [IDX_W-1:0] rd_bin;
  logic             capture;
  logic             xfer;
  logic             xfer_last;

  always_comb begin
    frame_accept = ~full[wr_sel];
    capture      = frame_valid & frame_accept;
    drop_pulse   = frame_valid & ~frame_accept;
    sample_valid = full[rd_sel];
    // fftshift order is a swap of the two halves, i.e. flipping the MSB.
    rd_bin       = (FFTSHIFT != 0) ? (pos ^ IDX_W'(N/2)) : pos;
    xfer         = sample_valid & sample_ready;
    xfer_last    = xfer & (pos == IDX_W'(N-1));
    sample_bin   = sample_valid ? rd_bin : '0;
    sample_out   = sample_valid ? bank[rd_sel][rd_bin] : '0;
    sample_first = sample_valid & (pos == '0);
    sample_last  = sample_valid & (pos == IDX_W'(N-1));
  end

  // Capture and final transfer always touch different banks: capture needs
  // full[wr_sel]=0 and a transfer needs full[rd_sel]=1, so both may apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      full       <= '0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      pos        <= '0;
      drop_count <= '0;
    end else begin
      if (capture) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (xfer) begin
        pos <= pos + IDX_W'(1);
      end
      if (xfer_last) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
      if (drop_pulse && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  // Bank storage carries no reset; contents are unobservable until rewritten.
  always_ff @(posedge clk) begin
    if (!reset && capture) begin
      bank[wr_sel] <= frame_in;
    end
  end

endmodule

// File: tb/tb_fft_frame_serializer.sv
module tb_fft_frame_serializer;
  import fft_frame_serializer_pkg::*;

  localparam int N     = 8;
  localparam int IDX_W = $clog2(N);
  localparam int VW    = 3 + $bits(complex_product_t) + IDX_W + 3 + 8;

  typedef complex_product_t [N-1:0] frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic   reset;
  frame_t frame_in;
  logic   frame_valid;
  logic   sample_ready;

  logic             accept_n, valid_n, first_n, last_n, drop_n;
  logic             accept_s, valid_s, first_s, last_s, drop_s;
  complex_product_t out_n, out_s;
  logic [IDX_W-1:0] bin_n, bin_s;
  logic [7:0]       cnt_n, cnt_s;

  fft_frame_serializer #(.N(N), .FFTSHIFT(0), .IDX_W(IDX_W)) u_nat (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_accept(accept_n), .sample_out(out_n), .sample_valid(valid_n),
    .sample_ready(sample_ready), .sample_bin(bin_n), .sample_first(first_n),
    .sample_last(last_n), .drop_pulse(drop_n), .drop_count(cnt_n));

  fft_frame_serializer #(.N(N), .FFTSHIFT(1), .IDX_W(IDX_W)) u_shf (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_accept(accept_s), .sample_out(out_s), .sample_valid(valid_s),
    .sample_ready(sample_ready), .sample_bin(bin_s), .sample_first(first_s),
    .sample_last(last_s), .drop_pulse(drop_s), .drop_count(cnt_s));

  logic [VW-1:0] obs_n, obs_s;
  assign obs_n = {accept_n, valid_n, out_n, bin_n, first_n, last_n, drop_n, cnt_n, 1'b0};
  assign obs_s = {accept_s, valid_s, out_s, bin_s, first_s, last_s, drop_s, cnt_s, 1'b0};

  int checks = 0;
  int errors = 0;

  // Reference model: a FIFO of at most two whole frames, the emit position
  // within the head frame, and the drop tally.
  frame_t mq[$];
  int     mpos  = 0;
  int     mdrop = 0;

  function automatic int emit_bin(int p, bit shift);
    if (!shift) return p;
    return (p < N/2) ? p + N/2 : p - N/2;
  endfunction

  function automatic logic [VW-1:0] model_vec(bit shift);
    bit               acc = (mq.size() < 2);
    bit               v   = (mq.size() > 0);
    complex_product_t o   = '0;
    logic [IDX_W-1:0] b   = '0;
    if (v) begin
      b = IDX_W'(emit_bin(mpos, shift));
      o = mq[0][emit_bin(mpos, shift)];
    end
    return {acc, v, o, b, v && (mpos == 0), v && (mpos == N-1),
            frame_valid && !acc, 8'(mdrop), 1'b0};
  endfunction

  function automatic void model_step();
    bit acc = (mq.size() < 2);
    bit v   = (mq.size() > 0);
    if (reset) begin
      mq.delete();
      mpos  = 0;
      mdrop = 0;
      return;
    end
    if (v && sample_ready) begin
      mpos++;
      if (mpos == N) begin
        mpos = 0;
        void'(mq.pop_front());
      end
    end
    if (frame_valid) begin
      if (acc) mq.push_back(frame_in);
      else if (mdrop < 255) mdrop++;
    end
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < N; k++) begin
      f[k].re = $urandom;
      f[k].im = $urandom;
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_valid = 1'b0; sample_ready = 1'b0; frame_in = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_n !== model_vec(0)) begin errors++; $display("FAIL reset_nat got %h exp %h", obs_n, model_vec(0)); end
    checks++;
    if (obs_s !== model_vec(1)) begin errors++; $display("FAIL reset_shf got %h exp %h", obs_s, model_vec(1)); end
    checks++;
    if ({accept_s, valid_s, bin_s, out_s} !== {1'b1, 1'b0, {IDX_W{1'b0}}, 64'd0}) begin
      errors++; $display("FAIL reset_outputs got acc=%b v=%b bin=%0d exp acc=1 v=0 bin=0", accept_s, valid_s, bin_s);
    end
    tick();
  endtask

  task automatic test_single();
    frame_t f;
    int seq_n[$];
    int seq_s[$];
    int exp_s[8] = '{4, 5, 6, 7, 0, 1, 2, 3};
    for (int k = 0; k < N; k++) begin
      f[k].re = k;
      f[k].im = -k;
    end
    for (int c = 0; c < N + 3; c++) begin
      frame_valid = (c == 0); frame_in = f; sample_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_n !== model_vec(0)) begin errors++; $display("FAIL single_nat cyc %0d got %h exp %h", c, obs_n, model_vec(0)); end
      checks++;
      if (obs_s !== model_vec(1)) begin errors++; $display("FAIL single_shf cyc %0d got %h exp %h", c, obs_s, model_vec(1)); end
      if (valid_n) seq_n.push_back(int'(bin_n));
      if (valid_s) seq_s.push_back(int'(bin_s));
      tick();
    end
    checks++;
    if (seq_n.size() != N || seq_s.size() != N) begin
      errors++; $display("FAIL single_count got %0d/%0d exp %0d", seq_n.size(), seq_s.size(), N);
    end else begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (seq_n[i] != i || seq_s[i] != exp_s[i]) begin
          errors++; $display("FAIL single_order idx %0d got %0d/%0d exp %0d/%0d", i, seq_n[i], seq_s[i], i, exp_s[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    frame_t f = rand_frame();
    for (int c = 0; c < 4*N + 4; c++) begin
      frame_valid = (c == 0); frame_in = f;
      sample_ready = (c % 4 == 0) || (c % 4 == 3);
      @(negedge clk);
      checks++;
      if (obs_n !== model_vec(0)) begin errors++; $display("FAIL bp_nat cyc %0d got %h exp %h", c, obs_n, model_vec(0)); end
      checks++;
      if (obs_s !== model_vec(1)) begin errors++; $display("FAIL bp_shf cyc %0d got %h exp %h", c, obs_s, model_vec(1)); end
      if (valid_n && sample_ready) xfers++;
      tick();
    end
    checks++;
    if (xfers != N) begin errors++; $display("FAIL bp_xfers got %0d exp %0d", xfers, N); end
  endtask

  task automatic test_overflow();
    int cnt0 = mdrop;
    for (int c = 0; c < 2*N + 10; c++) begin
      frame_valid = (c == 0) || (c == 3) || (c == 6);
      frame_in = rand_frame();
      sample_ready = (c >= 8);
      @(negedge clk);
      checks++;
      if (obs_n !== model_vec(0)) begin errors++; $display("FAIL ovf_nat cyc %0d got %h exp %h", c, obs_n, model_vec(0)); end
      checks++;
      if (obs_s !== model_vec(1)) begin errors++; $display("FAIL ovf_shf cyc %0d got %h exp %h", c, obs_s, model_vec(1)); end
      if (c == 6) begin
        checks++;
        if (drop_n !== 1'b1 || accept_n !== 1'b0) begin
          errors++; $display("FAIL ovf_drop got drop=%b acc=%b exp drop=1 acc=0", drop_n, accept_n);
        end
      end
      // Both frames must stream without a gap once ready rises.
      if (c >= 8 && c < 8 + 2*N) begin
        checks++;
        if (valid_n !== 1'b1) begin errors++; $display("FAIL ovf_gapless cyc %0d got valid=%b exp 1", c, valid_n); end
      end
      tick();
    end
    checks++;
    if (int'(cnt_n) != cnt0 + 1) begin errors++; $display("FAIL ovf_count got %0d exp %0d", cnt_n, cnt0 + 1); end
  endtask

  task automatic test_coincidence();
    bit d_done = 0;
    bit e_sent = 0;
    for (int c = 0; c < 3*N + 12; c++) begin
      frame_in = rand_frame();
      sample_ready = (c >= 4);
      frame_valid = (c == 0) || (c == 2);
      if (d_done && !e_sent) begin frame_valid = 1'b1; e_sent = 1; end
      else if (!d_done && sample_ready && mq.size() == 2 && mpos == N-1) begin frame_valid = 1'b1; d_done = 1; end
      @(negedge clk);
      checks++;
      if (obs_n !== model_vec(0)) begin errors++; $display("FAIL coin_nat cyc %0d got %h exp %h", c, obs_n, model_vec(0)); end
      checks++;
      if (obs_s !== model_vec(1)) begin errors++; $display("FAIL coin_shf cyc %0d got %h exp %h", c, obs_s, model_vec(1)); end
      if (frame_valid && c > 2) begin
        checks++;
        if (e_sent && accept_n !== 1'b1) begin errors++; $display("FAIL coin_e_accept got %b exp 1", accept_n); end
        else if (!e_sent && (drop_n !== 1'b1 || last_n !== 1'b1)) begin
          errors++; $display("FAIL coin_d_drop got drop=%b last=%b exp 1/1", drop_n, last_n);
        end
      end
      tick();
    end
    checks++;
    if (!d_done || !e_sent) begin errors++; $display("FAIL coin_timeout got d=%b e=%b exp 1/1", d_done, e_sent); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < N + 10; c++) begin
      frame_in = rand_frame();
      frame_valid = (c == 0) || (c == 6);
      sample_ready = 1'b1;
      reset = (c == 4);
      @(negedge clk);
      if (!reset) begin
        checks++;
        if (obs_n !== model_vec(0)) begin errors++; $display("FAIL rmid_nat cyc %0d got %h exp %h", c, obs_n, model_vec(0)); end
        checks++;
        if (obs_s !== model_vec(1)) begin errors++; $display("FAIL rmid_shf cyc %0d got %h exp %h", c, obs_s, model_vec(1)); end
      end
      if (c == 5) begin
        checks++;
        if (valid_n !== 1'b0 || cnt_n !== 8'd0 || accept_n !== 1'b1) begin
          errors++; $display("FAIL rmid_after got v=%b cnt=%0d acc=%b exp 0/0/1", valid_n, cnt_n, accept_n);
        end
      end
      if (c == 7) begin
        checks++;
        if (first_n !== 1'b1 || bin_n !== '0 || bin_s !== IDX_W'(N/2)) begin
          errors++; $display("FAIL rmid_restart got first=%b bin=%0d/%0d exp 1 0/%0d", first_n, bin_n, bin_s, N/2);
        end
      end
      tick();
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      frame_in = rand_frame();
      frame_valid = ($urandom_range(0, 5) == 0);
      sample_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (obs_n !== model_vec(0)) begin errors++; $display("FAIL rand_nat cyc %0d got %h exp %h", c, obs_n, model_vec(0)); end
      checks++;
      if (obs_s !== model_vec(1)) begin errors++; $display("FAIL rand_shf cyc %0d got %h exp %h", c, obs_s, model_vec(1)); end
      tick();
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 270; c++) begin
      frame_in = rand_frame();
      frame_valid = 1'b1;
      sample_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (obs_n !== model_vec(0)) begin errors++; $display("FAIL sat_nat cyc %0d got %h exp %h", c, obs_n, model_vec(0)); end
      tick();
    end
    frame_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt_n !== 8'd255 || cnt_s !== 8'd255) begin
      errors++; $display("FAIL sat_hold got %0d/%0d exp 255", cnt_n, cnt_s);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_coincidence();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
